pipe_pal_sched: RTL

Issue scheduler for the `pipe_pal` arithmetic pipeline. It shares one pipeline issue port among N_REQ requesters using round-robin arbitration. It bounds in-flight operations with a credit counter returned by pipeline responses, and provides a flush sequence that drains the pipeline before reconfiguration. It sits between the requester fabric and the `pipe_pal` input stage.

---
 rtl/pipe_pal_sched.sv | 132 +++++++++++++
 1 files changed

// File: rtl/pipe_pal_sched.sv
// Round-robin issue scheduler for the pipe_pal pipeline, with credit limiting and a flush drain sequence.
// Optional feature macro PIPE_PAL_SCHED_PRIO0_EN: requester 0 gets strict priority over the rotation.
module pipe_pal_sched #(
   parameter  int unsigned W_DATA  = 32,
   parameter  int unsigned W_ADDR  = 16,
   parameter  int unsigned N_REQ   = 4,
   parameter  int unsigned MAX_OUT = 8,
   localparam int unsigned ID_W    = $clog2(N_REQ),
   localparam int unsigned CNT_W   = $clog2(MAX_OUT + 1)
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic [N_REQ-1:0]        i_req_valid,
   output logic [N_REQ-1:0]        o_req_ready,
   input  logic [N_REQ*W_DATA-1:0] i_req_data,
   input  logic [N_REQ*W_ADDR-1:0] i_req_addr,
   output logic                    o_pipe_valid,
   input  logic                    i_pipe_ready,
   output logic [W_DATA-1:0]       o_pipe_data,
   output logic [W_ADDR-1:0]       o_pipe_addr,
   output logic [ID_W-1:0]         o_pipe_id,
   input  logic                    i_rsp_valid,
   input  logic                    i_flush,
   output logic                    o_flush_done,
   output logic [CNT_W-1:0]        o_outstanding,
   output logic                    o_underflow
);

   typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

   state_t            state, state_nxt;
   logic [ID_W-1:0]   rr_ptr, win_id;
   logic              win_found, can_load, accept, rr_upd;
   logic              pipe_valid_nxt, flush_done_nxt, underflow_set;
   logic [CNT_W-1:0]  count_nxt;
   logic [W_DATA-1:0] req_data [N_REQ];
   logic [W_ADDR-1:0] req_addr [N_REQ];

   for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
      assign req_data[g] = i_req_data[g*W_DATA +: W_DATA];
      assign req_addr[g] = i_req_addr[g*W_ADDR +: W_ADDR];
   end

   // Arbitration: search starts one past the last winner; ready is a combinational grant.
   always_comb begin
      int unsigned idx;
      win_found = 1'b0;
      win_id    = '0;
      idx       = 0;
      for (int unsigned i = 1; i <= N_REQ; i++) begin
         idx = (32'(rr_ptr) + i) % N_REQ;
         if (!win_found && i_req_valid[ID_W'(idx)]) begin
            win_found = 1'b1;
            win_id    = ID_W'(idx);
         end
      end
`ifdef PIPE_PAL_SCHED_PRIO0_EN
      if (i_req_valid[0]) begin
         win_found = 1'b1;
         win_id    = '0;
      end
`endif
      can_load = (state == RUN) && (!o_pipe_valid || i_pipe_ready)
                 && (o_outstanding < CNT_W'(MAX_OUT));
      accept   = can_load && win_found && !i_reset;
`ifdef PIPE_PAL_SCHED_PRIO0_EN
      rr_upd   = accept && !i_req_valid[0];
`else
      rr_upd   = accept;
`endif
      o_req_ready = '0;
      if (accept) o_req_ready[win_id] = 1'b1;
   end

   // Credit and issue-slot next values; drain completion looks at these so the pulse lands one cycle after the last retire.
   always_comb begin
      count_nxt     = o_outstanding;
      underflow_set = i_rsp_valid && (o_outstanding == '0);
      if (accept && !i_rsp_valid)
         count_nxt = o_outstanding + CNT_W'(1);
      else if (!accept && i_rsp_valid && (o_outstanding != '0))
         count_nxt = o_outstanding - CNT_W'(1);
      pipe_valid_nxt = accept || (o_pipe_valid && !i_pipe_ready);
   end

   always_comb begin
      state_nxt      = state;
      flush_done_nxt = 1'b0;
      unique case (state)
         RUN:     if (i_flush) state_nxt = DRAIN;
         DRAIN:   if ((count_nxt == '0) && !pipe_valid_nxt) begin
                     state_nxt      = DONE;
                     flush_done_nxt = 1'b1;
                  end
         DONE:    if (!i_flush) state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state        <= RUN;
         o_flush_done <= 1'b0;
      end else begin
         state        <= state_nxt;
         o_flush_done <= flush_done_nxt;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         rr_ptr        <= ID_W'(N_REQ - 1);
         o_pipe_valid  <= 1'b0;
         o_pipe_data   <= '0;
         o_pipe_addr   <= '0;
         o_pipe_id     <= '0;
         o_outstanding <= '0;
         o_underflow   <= 1'b0;
      end else begin
         o_pipe_valid  <= pipe_valid_nxt;
         o_outstanding <= count_nxt;
         if (underflow_set) o_underflow <= 1'b1;
         if (accept) begin
            o_pipe_data <= req_data[win_id];
            o_pipe_addr <= req_addr[win_id];
            o_pipe_id   <= win_id;
         end
         if (rr_upd) rr_ptr <= win_id;
      end
   end

endmodule
